// File: rtl/com4_arb_if.sv
// Requester/arbiter bus for com4_arb: two request/frame/grant triplets plus the
// registered outbound frame bytes, busy flag and owner index.
interface com4_arb_if;
  logic        REQ0;
  logic [31:0] FRAME0;
  logic        GNT0;
  logic        REQ1;
  logic [31:0] FRAME1;
  logic        GNT1;
  logic [7:0]  DATA_OUT0;
  logic [7:0]  DATA_OUT1;
  logic [7:0]  DATA_OUT2;
  logic [7:0]  DATA_OUT3;
  logic        BUSY;
  logic        OWNER;

  // Requesters drive requests/frames and observe grants and the outbound frame.
  modport master (
    output REQ0, FRAME0, REQ1, FRAME1,
    input  GNT0, GNT1, DATA_OUT0, DATA_OUT1, DATA_OUT2, DATA_OUT3, BUSY, OWNER
  );

  modport slave (
    input  REQ0, FRAME0, REQ1, FRAME1,
    output GNT0, GNT1, DATA_OUT0, DATA_OUT1, DATA_OUT2, DATA_OUT3, BUSY, OWNER
  );
endinterface

// File: rtl/com4_arb.sv
// Two-requester round-robin arbiter publishing a captured 32-bit frame for at least
// HOLD_CYCLES cycles. Optional macro COM4_ARB_SEQ_EN replaces byte 3 with {OWNER, seq}.
module com4_arb #(
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic      CLK,
  input  logic      RST,
  com4_arb_if.slave bus
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("com4_arb: HOLD_CYCLES out of range 1..65535");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic        ptr_q,   ptr_d;
  logic        gnt0_q,  gnt0_d;
  logic        gnt1_q,  gnt1_d;
  logic        owner_q, owner_d;
  logic        busy_q,  busy_d;
  logic [31:0] data_q,  data_d;
  logic        sel;
  logic [31:0] frame_sel;
`ifdef COM4_ARB_SEQ_EN
  logic [6:0]  seq_q,   seq_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    owner_d = owner_q;
    busy_d  = busy_q;
    data_d  = data_q;
`ifdef COM4_ARB_SEQ_EN
    seq_d   = seq_q;
`endif
    // Pointer only decides under contention; a lone request wins regardless.
    sel       = (bus.REQ0 && bus.REQ1) ? ptr_q : bus.REQ1;
    frame_sel = sel ? bus.FRAME1 : bus.FRAME0;

    case (state_q)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          owner_d = sel;
          ptr_d   = ~sel;
          busy_d  = 1'b1;
          data_d  = frame_sel;
`ifdef COM4_ARB_SEQ_EN
          data_d[31:24] = {sel, seq_q};
          seq_d         = seq_q + 7'd1;
`endif
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
`ifdef COM4_ARB_SEQ_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
`ifdef COM4_ARB_SEQ_EN
      seq_q   <= seq_d;
`endif
    end
  end

  assign bus.GNT0      = gnt0_q;
  assign bus.GNT1      = gnt1_q;
  assign bus.OWNER     = owner_q;
  assign bus.BUSY      = busy_q;
  assign bus.DATA_OUT0 = data_q[7:0];
  assign bus.DATA_OUT1 = data_q[15:8];
  assign bus.DATA_OUT2 = data_q[23:16];
  assign bus.DATA_OUT3 = data_q[31:24];

endmodule

// File: tb/tb_com4_arb.sv
// Bench for com4_arb: table of request vectors on a HOLD_CYCLES=4 instance with a grant
// scoreboard, plus hand-written contention, reset-mid-hold and HOLD_CYCLES=1 sequences.
module tb_com4_arb;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  com4_arb_if bus4 ();
  com4_arb_if bus1 ();

  com4_arb #(.HOLD_CYCLES(4)) dut4 (.CLK(clk), .RST(rst), .bus(bus4.slave));
  com4_arb #(.HOLD_CYCLES(1)) dut1 (.CLK(clk), .RST(rst), .bus(bus1.slave));

  typedef struct {
    logic        r0;
    logic        r1;
    logic [31:0] f0;
    logic [31:0] f1;
    logic        exp_gnt;
    logic        exp_idx;
  } vec_t;

  typedef struct {
    logic        idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[9];
  logic [31:0] last_data;
`ifdef COM4_ARB_SEQ_EN
  logic [6:0]  exp_seq4 = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic idx, input logic [31:0] frame, output logic [31:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = frame;
`ifdef COM4_ARB_SEQ_EN
    e.data[31:24] = {idx, exp_seq4};
    exp_seq4      = exp_seq4 + 7'd1;
`endif
    data = e.data;
    sb.push_back(e);
  endtask

  task automatic seq_reset();
`ifdef COM4_ARB_SEQ_EN
    exp_seq4 = '0;
`endif
  endtask

  function automatic logic [31:0] out4();
    return {bus4.DATA_OUT3, bus4.DATA_OUT2, bus4.DATA_OUT1, bus4.DATA_OUT0};
  endfunction

  // Scoreboard consumer: every grant pulse on the HOLD_CYCLES=4 instance pops one entry.
  always @(negedge clk) begin
    if (bus4.GNT0 || bus4.GNT1) begin
      check("gnt_exclusive", {31'd0, bus4.GNT0 & bus4.GNT1}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_gnt", {30'd0, bus4.GNT1, bus4.GNT0}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("gnt_idx", {30'd0, bus4.GNT1, bus4.GNT0}, e.idx ? 32'd2 : 32'd1);
        check("gnt_data", out4(), e.data);
        check("gnt_owner", {31'd0, bus4.OWNER}, {31'd0, e.idx});
        check("gnt_busy", {31'd0, bus4.BUSY}, 32'd1);
      end
    end
  end

  task automatic wait_idle4();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!bus4.BUSY) break;
    end
    check("idle_timeout", {31'd0, bus4.BUSY}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seq_reset();
  endtask

  task automatic apply_vec(input vec_t v);
    logic [31:0] exp_d;
    int          bcnt;
    logic        hold_ok;
    exp_d = '0;
    @(posedge clk); #1;
    bus4.REQ0   = v.r0;
    bus4.REQ1   = v.r1;
    bus4.FRAME0 = v.f0;
    bus4.FRAME1 = v.f1;
    if (v.exp_gnt) push_exp(v.exp_idx, v.exp_idx ? v.f1 : v.f0, exp_d);
    @(posedge clk); #1;
    bus4.REQ0   = 1'b0;
    bus4.REQ1   = 1'b0;
    bus4.FRAME0 = ~v.f0;
    bus4.FRAME1 = ~v.f1;
    if (v.exp_gnt) begin
      bcnt    = 0;
      hold_ok = 1'b1;
      // Requests and frames wiggle during HOLD; none of it may reach the outputs.
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (!bus4.BUSY) break;
        bcnt++;
        if (out4() !== exp_d) hold_ok = 1'b0;
        bus4.REQ1   = 1'($urandom_range(0, 1));
        bus4.FRAME0 = $urandom;
        bus4.FRAME1 = $urandom;
      end
      bus4.REQ1 = 1'b0;
      check("busy_cycles", bcnt, 32'd4);
      check("hold_stable", {31'd0, hold_ok}, 32'd1);
      last_data = exp_d;
    end else begin
      repeat (3) @(negedge clk);
      check("idle_busy", {31'd0, bus4.BUSY}, 32'd0);
      check("idle_data_held", out4(), last_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   gcyc[$];
    int   ng;
    logic ok;
    logic [31:0] d;

    tbl[0] = '{1'b1, 1'b0, 32'h44332211, 32'hA5A5A5A5, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h01020304, 32'h0A0B0C0D, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'h11111111, 32'h89ABCDEF, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'h22222222, 32'h76543210, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 32'h13579BDF, 32'h02468ACE, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 32'h5A5A5A5A, 32'hC3C3C3C3, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 32'h12345678, 32'h87654321, 1'b0, 1'b0};

    bus1.REQ0 = 1'b0; bus1.REQ1 = 1'b0; bus1.FRAME0 = '0; bus1.FRAME1 = '0;
    bus4.REQ1 = 1'b0; bus4.FRAME0 = 32'h99887766; bus4.FRAME1 = '0;
    // Reset wins over a request present on the same edge.
    rst = 1'b1;
    bus4.REQ0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_no_gnt", {30'd0, bus4.GNT1, bus4.GNT0}, 32'd0);
    check("rst_busy", {31'd0, bus4.BUSY}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus4.REQ0 = 1'b0;
    seq_reset();
    @(negedge clk);
    check("rst_data", out4(), 32'd0);
    check("rst_owner", {31'd0, bus4.OWNER}, 32'd0);
    last_data = '0;

    for (int i = 0; i < 9; i++) apply_vec(tbl[i]);

    // Contention held from reset: 0,1,0 spaced HOLD_CYCLES+1 apart.
    pulse_reset();
    bus4.FRAME0 = 32'hA0A1A2A3;
    bus4.FRAME1 = 32'hB0B1B2B3;
    bus4.REQ0 = 1'b1;
    bus4.REQ1 = 1'b1;
    push_exp(1'b0, 32'hA0A1A2A3, d);
    push_exp(1'b1, 32'hB0B1B2B3, d);
    push_exp(1'b0, 32'hA0A1A2A3, d);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus4.GNT0 || bus4.GNT1) gcyc.push_back(cyc);
      if (gcyc.size() == 3) break;
    end
    bus4.REQ0 = 1'b0;
    bus4.REQ1 = 1'b0;
    check("contention_grants", gcyc.size(), 32'd3);
    if (gcyc.size() == 3) begin
      check("contention_gap1", gcyc[1] - gcyc[0], 32'd5);
      check("contention_gap2", gcyc[2] - gcyc[1], 32'd5);
    end
    wait_idle4();

    // Reset on the second HOLD cycle, then a lone REQ1 despite pointer 0.
    @(posedge clk); #1;
    bus4.REQ0   = 1'b1;
    bus4.FRAME0 = 32'hCAFEBABE;
    push_exp(1'b0, 32'hCAFEBABE, d);
    @(posedge clk); #1;
    bus4.REQ0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seq_reset();
    bus4.REQ1   = 1'b1;
    bus4.FRAME1 = 32'h0BADF00D;
    push_exp(1'b1, 32'h0BADF00D, d);
    @(negedge clk);
    check("midhold_rst_data", out4(), 32'd0);
    check("midhold_rst_busy", {31'd0, bus4.BUSY}, 32'd0);
    @(posedge clk); #1;
    bus4.REQ1 = 1'b0;
    wait_idle4();

    // HOLD_CYCLES=1: held REQ0 is granted every second cycle, BUSY tracks the grant.
    @(posedge clk); #1;
    bus1.REQ0   = 1'b1;
    bus1.FRAME0 = 32'h76543210;
    gcyc.delete();
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus1.GNT0) gcyc.push_back(cyc);
      if (bus1.BUSY !== bus1.GNT0) ok = 1'b0;
      if (bus1.GNT1) ok = 1'b0;
    end
    bus1.REQ0 = 1'b0;
    check("h1_grants", gcyc.size(), 32'd6);
    check("h1_busy_matches_gnt", {31'd0, ok}, 32'd1);
    ok = 1'b1;
    for (int i = 1; i < gcyc.size(); i++) if (gcyc[i] - gcyc[i-1] != 2) ok = 1'b0;
    check("h1_spacing", {31'd0, ok}, 32'd1);
    @(negedge clk);

`ifdef COM4_ARB_SEQ_EN
    // 130 grants to REQ1: byte 3 = {1, seq} with seq wrapping 127 -> 0.
    pulse_reset();
    bus1.REQ1 = 1'b1;
    ng = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus1.GNT1) begin
        check("seq_byte3", {24'd0, bus1.DATA_OUT3}, {24'd0, 1'b1, 7'(ng)});
        ng++;
      end
      if (ng == 130) break;
    end
    bus1.REQ1 = 1'b0;
    check("seq_grants", ng, 32'd130);
    @(negedge clk);
`else
    ng = 0;
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
